// File: rtl/x_branch_predict_unit.sv
// x_branch_predict_unit
//
// Execute-stage branch resolution with a direct-mapped table of saturating
// counters. The fetch stage gets a combinational taken/not-taken prediction;
// the execute stage resolves the branch against the prediction it carried
// down the pipe, redirects only on a mispredict, and then holds flush for
// FLUSH_CYCLES cycles in total so deeper pipelines can drain.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   f_valid, f_pc       fetch lookup request
//   f_pred_taken        prediction for f_pc (reads pre-update table)
//   x_valid, x_opcode,
//   x_funct3, x_pc      execute-stage instruction
//   x_pred_taken        prediction that travelled with this instruction
//   BrEq, BrLT          comparator results
//   BrUn                unsigned compare select to the comparator
//   redirect            PC override this cycle (mispredict only)
//   redirect_sel        0 = branch target, 1 = x_pc+4
//   flush               squash younger instructions
//   branch_taken        resolved branch outcome
//   branch_count        resolved branches (wraps)
//   mispredict_count    mispredicted branches (wraps)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | branches resolve normally
// ST_FLUSH | post-mispredict window: flush held, X-stage branches ignored

module x_branch_predict_unit #(
    parameter int BHT_DEPTH    = 64,
    parameter int CTR_BITS     = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int STAT_BITS    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 f_valid,
    input  logic [31:0]          f_pc,
    output logic                 f_pred_taken,
    input  logic                 x_valid,
    input  logic [6:0]           x_opcode,
    input  logic [2:0]           x_funct3,
    input  logic [31:0]          x_pc,
    input  logic                 x_pred_taken,
    input  logic                 BrEq,
    input  logic                 BrLT,
    output logic                 BrUn,
    output logic                 redirect,
    output logic                 redirect_sel,
    output logic                 flush,
    output logic                 branch_taken,
    output logic [STAT_BITS-1:0] branch_count,
    output logic [STAT_BITS-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};

    typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

    state_t              state_q, state_nxt;
    logic [CNT_W-1:0]    cnt_q, cnt_nxt;
    logic [CTR_BITS-1:0] bht [BHT_DEPTH];
    logic [STAT_BITS-1:0] branch_count_q, mispredict_count_q;

    logic [IDX_W-1:0] f_idx, x_idx;
    logic             is_branch, f3_legal, outcome, resolve, mispredict;
    logic             unused_pc_bits;

    assign f_idx = f_pc[IDX_W+1:2];
    assign x_idx = x_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{f_pc[31:IDX_W+2], f_pc[1:0], x_pc[31:IDX_W+2], x_pc[1:0]};

    assign f_pred_taken = f_valid & bht[f_idx][CTR_BITS-1];

    assign is_branch = (x_opcode == OPC_BRANCH);

    always_comb begin
        outcome  = 1'b0;
        f3_legal = 1'b1;
        case (x_funct3)
            3'b000:  outcome = BrEq;
            3'b001:  outcome = ~BrEq;
            3'b100:  outcome = BrLT;
            3'b101:  outcome = ~BrLT;
            3'b110:  outcome = BrLT;
            3'b111:  outcome = ~BrLT;
            default: f3_legal = 1'b0;
        endcase
    end

    // Gating with reset keeps the flush/redirect outputs quiet the moment
    // reset rises, even if the X-stage inputs still show a mispredict.
    assign resolve    = ~reset & x_valid & is_branch & f3_legal & (state_q == ST_IDLE);
    assign mispredict = resolve & (outcome != x_pred_taken);

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // FSM: next state. cnt holds the flush cycles still owed after the
    // mispredict cycle itself, so the window is exactly FLUSH_CYCLES long.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mispredict && FLUSH_CYCLES > 1) begin
                    state_nxt = ST_FLUSH;
                    cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            ST_FLUSH: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        redirect     = mispredict;
        redirect_sel = ~outcome;
        branch_taken = resolve & outcome;
        flush        = mispredict | (state_q == ST_FLUSH);
        BrUn         = ~reset & is_branch & (x_funct3[2:1] == 2'b11);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CTR_INIT;
        end else if (resolve) begin
            if (outcome && bht[x_idx] != CTR_MAX)
                bht[x_idx] <= bht[x_idx] + CTR_BITS'(1);
            else if (!outcome && bht[x_idx] != '0)
                bht[x_idx] <= bht[x_idx] - CTR_BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            if (resolve)
                branch_count_q <= branch_count_q + STAT_BITS'(1);
            if (mispredict)
                mispredict_count_q <= mispredict_count_q + STAT_BITS'(1);
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_x_branch_predict_unit.sv
module tb_x_branch_predict_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_valid;
    logic [31:0] f_pc;
    logic        x_valid;
    logic [6:0]  x_opcode;
    logic [2:0]  x_funct3;
    logic [31:0] x_pc;
    logic        x_pred_taken;
    logic        BrEq, BrLT;

    logic [1:0]  o_fpred, o_brun, o_redir, o_sel, o_flush, o_taken;
    logic [31:0] o_bc [2];
    logic [31:0] o_mc [2];

    int checks = 0;
    int errors = 0;

    // Reference model: instance 0 = defaults, instance 1 = depth 4 / flush 3
    int          m_depth [2] = '{64, 4};
    int          m_fc    [2] = '{2, 3};
    int          m_bht   [2][64];
    int          m_fl    [2];
    int unsigned m_bc    [2];
    int unsigned m_mc    [2];

    always #5 clk = ~clk;

    x_branch_predict_unit dut_a (
        .clk(clk), .reset(reset), .f_valid(f_valid), .f_pc(f_pc),
        .f_pred_taken(o_fpred[0]), .x_valid(x_valid), .x_opcode(x_opcode),
        .x_funct3(x_funct3), .x_pc(x_pc), .x_pred_taken(x_pred_taken),
        .BrEq(BrEq), .BrLT(BrLT), .BrUn(o_brun[0]), .redirect(o_redir[0]),
        .redirect_sel(o_sel[0]), .flush(o_flush[0]), .branch_taken(o_taken[0]),
        .branch_count(o_bc[0]), .mispredict_count(o_mc[0])
    );

    x_branch_predict_unit #(.BHT_DEPTH(4), .FLUSH_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .f_valid(f_valid), .f_pc(f_pc),
        .f_pred_taken(o_fpred[1]), .x_valid(x_valid), .x_opcode(x_opcode),
        .x_funct3(x_funct3), .x_pc(x_pc), .x_pred_taken(x_pred_taken),
        .BrEq(BrEq), .BrLT(BrLT), .BrUn(o_brun[1]), .redirect(o_redir[1]),
        .redirect_sel(o_sel[1]), .flush(o_flush[1]), .branch_taken(o_taken[1]),
        .branch_count(o_bc[1]), .mispredict_count(o_mc[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc, input int k);
        return int'(pc >> 2) % m_depth[k];
    endfunction

    // Counter in the upper half of its range means "taken"
    function automatic logic model_pred(input int k, input logic [31:0] pc);
        return m_bht[k][idx_of(pc, k)] >= 2;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 64; i++) m_bht[k][i] = 1;
            m_fl[k] = 0;
            m_bc[k] = 0;
            m_mc[k] = 0;
        end
    endtask

    // One clock: check combinational outputs against the model, then take
    // the edge and advance the model. Inputs change only at posedge+1.
    task automatic cycle();
        logic res [2];
        logic mis [2];
        logic out;
        logic is_br, legal;
        #1;
        is_br = (x_opcode == 7'h63);
        legal = !(x_funct3 == 3'd2 || x_funct3 == 3'd3);
        case (x_funct3)
            3'd0: out = BrEq;
            3'd1: out = !BrEq;
            3'd4, 3'd6: out = BrLT;
            3'd5, 3'd7: out = !BrLT;
            default: out = 1'b0;
        endcase
        for (int k = 0; k < 2; k++) begin
            res[k] = !reset && m_fl[k] == 0 && x_valid && is_br && legal;
            mis[k] = res[k] && (out != x_pred_taken);
            chk($sformatf("f_pred[%0d]", k), 32'(o_fpred[k]), 32'(f_valid && model_pred(k, f_pc)));
            chk($sformatf("redirect[%0d]", k), 32'(o_redir[k]), 32'(mis[k]));
            chk($sformatf("flush[%0d]", k), 32'(o_flush[k]), 32'(!reset && (mis[k] || m_fl[k] > 0)));
            chk($sformatf("taken[%0d]", k), 32'(o_taken[k]), 32'(res[k] && out));
            chk($sformatf("BrUn[%0d]", k), 32'(o_brun[k]), 32'(!reset && is_br && x_funct3 >= 3'd6));
            if (mis[k])
                chk($sformatf("redirect_sel[%0d]", k), 32'(o_sel[k]), 32'(!out));
            chk($sformatf("branch_count[%0d]", k), o_bc[k], m_bc[k]);
            chk($sformatf("mispredict_count[%0d]", k), o_mc[k], m_mc[k]);
        end
        @(posedge clk);
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                if (res[k]) begin
                    int i = idx_of(x_pc, k);
                    if (out && m_bht[k][i] < 3) m_bht[k][i]++;
                    if (!out && m_bht[k][i] > 0) m_bht[k][i]--;
                    m_bc[k]++;
                    if (mis[k]) m_mc[k]++;
                end
                if (m_fl[k] > 0) m_fl[k]--;
                else if (mis[k]) m_fl[k] = m_fc[k] - 1;
            end
        end
        #1;
    endtask

    task automatic set_x(input logic v, input logic [2:0] f3, input logic [31:0] pc,
                         input logic pred, input logic eq, input logic lt);
        x_valid = v; x_opcode = 7'h63; x_funct3 = f3; x_pc = pc;
        x_pred_taken = pred; BrEq = eq; BrLT = lt;
    endtask

    task automatic idle(input int n);
        x_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic sweep_preds();
        f_valid = 1'b1;
        x_valid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            f_pc = 32'(i * 4);
            cycle();
        end
    endtask

    initial begin
        reset = 1'b1; f_valid = 1'b0; f_pc = '0;
        set_x(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(posedge clk); #1;
        cycle();
        reset = 1'b0;
        sweep_preds();

        // Cold taken BEQ at 0x100: mispredict; fetch of the same pc sees old value
        f_valid = 1'b1; f_pc = 32'h100;
        set_x(1'b1, 3'd0, 32'h100, 1'b0, 1'b1, 1'b0);
        cycle();
        x_valid = 1'b0;
        cycle();
        chk("cold_mc", o_mc[0], 32'd1);
        chk("cold_pred_after", 32'(o_fpred[0]), 32'd1);
        idle(3);

        // Saturation: five taken BNEs at 0x200, then two not-taken
        f_pc = 32'h200;
        for (int n = 0; n < 5; n++) begin
            set_x(1'b1, 3'd1, 32'h200, model_pred(0, 32'h200), 1'b0, 1'b0);
            cycle();
            idle(3);
        end
        set_x(1'b1, 3'd1, 32'h200, model_pred(0, 32'h200), 1'b1, 1'b0);
        cycle();
        idle(3);
        chk("sat_pred_weak_taken", 32'(o_fpred[0]), 32'd1);
        set_x(1'b1, 3'd1, 32'h200, model_pred(0, 32'h200), 1'b1, 1'b0);
        cycle();
        idle(3);
        chk("sat_pred_not_taken", 32'(o_fpred[0]), 32'd0);

        // BLTU correctly predicted taken, then an illegal funct3
        set_x(1'b1, 3'd6, 32'h300, 1'b1, 1'b0, 1'b1);
        cycle();
        set_x(1'b1, 3'd2, 32'h300, 1'b0, 1'b1, 1'b1);
        cycle();
        idle(3);

        // Flush window squash: mispredict then branches in the following cycles
        set_x(1'b1, 3'd0, 32'h40, 1'b0, 1'b1, 1'b0);
        cycle();
        set_x(1'b1, 3'd0, 32'h44, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle();
        idle(3);

        // Aliasing on the depth-4 table: 0x0 and 0x10 share index 0, with
        // a same-index fetch lookup during the update
        f_pc = 32'h10;
        for (int n = 0; n < 3; n++) begin
            set_x(1'b1, 3'd0, 32'h0, model_pred(1, 32'h0), 1'b1, 1'b0);
            cycle();
            idle(3);
        end
        f_pc = 32'h0;
        set_x(1'b1, 3'd0, 32'h10, model_pred(1, 32'h10), 1'b0, 1'b0);
        cycle();
        idle(3);

        // Reset mid-flush
        set_x(1'b1, 3'd0, 32'h80, 1'b0, 1'b1, 1'b0);
        cycle();
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_flush_a", 32'(o_flush[0]), 32'd0);
        chk("rst_flush_b", 32'(o_flush[1]), 32'd0);
        cycle();
        reset = 1'b0;
        sweep_preds();

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            f_valid      = 1'($urandom);
            f_pc         = 32'($urandom_range(0, 31) * 4);
            x_valid      = ($urandom_range(0, 3) != 0);
            x_opcode     = ($urandom_range(0, 7) != 0) ? 7'h63 : 7'($urandom);
            x_funct3     = 3'($urandom);
            x_pc         = 32'($urandom_range(0, 31) * 4);
            x_pred_taken = ($urandom_range(0, 3) == 0) ? 1'($urandom) : model_pred(0, x_pc);
            BrEq         = 1'($urandom);
            BrLT         = 1'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
                #1;
                model_reset();
                cycle();
                reset = 1'b0;
            end else begin
                cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
